// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single synchronous RAM: round-robin between
// requesters, optional lock for read-modify-write, one-cycle read return.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  req0,
  input  logic                  we0_,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  lock0,
  input  logic                  req1,
  input  logic                  we1_,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic                  lock1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we_,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  logic last_q, last_d;
  logic rvalid0_q, rvalid0_d;
  logic rvalid1_q, rvalid1_d;

  logic grant_valid;
  logic grant_port;
  logic req_last;
  logic lock_last;

  assign req_last  = last_q ? req1 : req0;
  assign lock_last = last_q ? lock1 : lock0;

  // Lock by the current owner outranks round-robin; a lock on the other port
  // is ignored until that port becomes the owner.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    if (reset_) begin
      if (lock_last && req_last) begin
        grant_valid = 1'b1;
        grant_port  = last_q;
      end else if (req0 && req1) begin
        grant_valid = 1'b1;
        grant_port  = ~last_q;
      end else if (req0) begin
        grant_valid = 1'b1;
        grant_port  = 1'b0;
      end else if (req1) begin
        grant_valid = 1'b1;
        grant_port  = 1'b1;
      end
    end
  end

  assign ack0 = grant_valid && !grant_port;
  assign ack1 = grant_valid && grant_port;

  always_comb begin
    mem_addr = addr0;
    mem_din  = din0;
    mem_we_  = 1'b1;
    if (ack1) begin
      mem_addr = addr1;
      mem_din  = din1;
      mem_we_  = we1_;
    end else if (ack0) begin
      mem_we_  = we0_;
    end
  end

  always_comb begin
    last_d    = grant_valid ? grant_port : last_q;
    rvalid0_d = ack0 && we0_;
    rvalid1_d = ack1 && we1_;
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // Read data is shared; only the per-port valid tells who it belongs to.
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = mem_dout;
  assign rdata1  = mem_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural synchronous RAM
// attached to the memory side.
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        reset_;
  logic        req0, we0_, lock0, req1, we1_, lock1;
  logic [15:0] addr0, din0, addr1, din1;
  logic        ack0, ack1, rvalid0, rvalid1, mem_we_;
  logic [15:0] rdata0, rdata1, mem_addr, mem_din, mem_dout;
  logic [15:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset_(reset_),
    .req0(req0), .we0_(we0_), .addr0(addr0), .din0(din0), .lock0(lock0),
    .req1(req1), .we1_(we1_), .addr1(addr1), .din1(din1), .lock1(lock1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we_(mem_we_), .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    if (!mem_we_) mem[mem_addr[7:0]] <= mem_din;
    mem_dout <= mem[mem_addr[7:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; we0_ = 1; lock0 = 0; addr0 = 16'h0; din0 = 16'h0;
    req1 = 0; we1_ = 1; lock1 = 0; addr1 = 16'h0; din1 = 16'h0;
  endtask

  task automatic do_reset();
    reset_ = 0;
    tick();
    tick();
    reset_ = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_ = 0;
    req0 = 1; we0_ = 0; req1 = 1; we1_ = 0;
    tick();
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0 got %b want 0", ack0); end
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1 got %b want 0", ack1); end
    checks++; if (mem_we_ !== 1'b1) begin errors++; $display("FAIL reset_mem_we got %b want 1", mem_we_); end
    checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b%b want 00", rvalid0, rvalid1); end
    idle_inputs();
    tick();
    reset_ = 1;
  endtask

  task automatic test_write_read();
    do_reset();
    req0 = 1; we0_ = 0; addr0 = 16'h0010; din0 = 16'hBEEF;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin errors++; $display("FAIL wr_ack got %b%b want 10", ack0, ack1); end
    checks++; if (mem_we_ !== 1'b0 || mem_addr !== 16'h0010 || mem_din !== 16'hBEEF) begin
      errors++; $display("FAIL wr_mem got we_=%b addr=%h din=%h want 0/0010/beef", mem_we_, mem_addr, mem_din); end
    tick();
    we0_ = 1;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1 || mem_we_ !== 1'b1) begin errors++; $display("FAIL rd_ack got ack0=%b we_=%b want 1/1", ack0, mem_we_); end
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b want 0", rvalid0); end
    tick();
    req0 = 0;
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0) begin errors++; $display("FAIL rd_rvalid got %b%b want 10", rvalid0, rvalid1); end
    checks++; if (rdata0 !== 16'hBEEF) begin errors++; $display("FAIL rd_data got %h want beef", rdata0); end
    tick();
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL rd_rvalid_once got %b want 0", rvalid0); end
  endtask

  task automatic test_round_robin();
    logic exp_ack0 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic exp_rv0  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic exp_rv1  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    req0 = 1; we0_ = 1; addr0 = 16'h0010;
    req1 = 1; we1_ = 1; addr1 = 16'h0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (ack0 !== exp_ack0[k] || ack1 !== !exp_ack0[k]) begin
        errors++; $display("FAIL rr_ack[%0d] got %b%b want %b%b", k, ack0, ack1, exp_ack0[k], !exp_ack0[k]); end
      checks++; if (rvalid0 !== exp_rv0[k] || rvalid1 !== exp_rv1[k]) begin
        errors++; $display("FAIL rr_rvalid[%0d] got %b%b want %b%b", k, rvalid0, rvalid1, exp_rv0[k], exp_rv1[k]); end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b1 || rdata1 !== 16'hBEEF) begin
      errors++; $display("FAIL rr_last_rvalid got %b%b data=%h want 01 beef", rvalid0, rvalid1, rdata1); end
    tick();
  endtask

  task automatic test_ordering();
    do_reset();
    req1 = 1; we1_ = 0; addr1 = 16'h0020; din1 = 16'h1111;
    @(negedge clk);
    checks++; if (ack1 !== 1'b1 || mem_we_ !== 1'b0 || mem_din !== 16'h1111) begin
      errors++; $display("FAIL ord_preload got ack1=%b we_=%b din=%h want 1/0/1111", ack1, mem_we_, mem_din); end
    tick();
    idle_inputs();
    do_reset();
    req0 = 1; we0_ = 0; addr0 = 16'h0020; din0 = 16'h2222;
    req1 = 1; we1_ = 1; addr1 = 16'h0020;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0 || mem_we_ !== 1'b0) begin
      errors++; $display("FAIL ord_first got %b%b we_=%b want 10 0", ack0, ack1, mem_we_); end
    tick();
    req0 = 0;
    @(negedge clk);
    checks++; if (ack1 !== 1'b1 || mem_addr !== 16'h0020 || mem_we_ !== 1'b1) begin
      errors++; $display("FAIL ord_second got ack1=%b addr=%h we_=%b want 1/0020/1", ack1, mem_addr, mem_we_); end
    tick();
    req1 = 0;
    @(negedge clk);
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 16'h2222) begin
      errors++; $display("FAIL ord_data got rvalid1=%b data=%h want 1/2222", rvalid1, rdata1); end
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    req0 = 1; we0_ = 1; lock0 = 1; addr0 = 16'h0010;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL lock_first got %b want 1", ack0); end
    tick();
    req1 = 1; we1_ = 1; addr1 = 16'h0020;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
        errors++; $display("FAIL lock_hold[%0d] got %b%b want 10", k, ack0, ack1); end
      tick();
    end
    lock0 = 0;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0 || ack1 !== 1'b1) begin errors++; $display("FAIL lock_release got %b%b want 01", ack0, ack1); end
    tick();
    // port 1 now owns; its lock with req low must not stall port 0
    req0 = 1; req1 = 0; lock1 = 1;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin errors++; $display("FAIL lock_noreq got %b%b want 10", ack0, ack1); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_after_read();
    do_reset();
    req0 = 1; we0_ = 1; addr0 = 16'h0010;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL rst_rd_ack got %b want 1", ack0); end
    reset_ = 0;
    req1 = 1; we1_ = 0; we0_ = 0;
    #1;
    checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0 || mem_we_ !== 1'b1) begin
      errors++; $display("FAIL rst_comb got %b%b we_=%b want 00 1", ack0, ack1, mem_we_); end
    tick();
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL rst_rvalid_lost got %b want 0", rvalid0); end
    checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0 || mem_we_ !== 1'b1) begin
      errors++; $display("FAIL rst_hold got %b%b we_=%b want 00 1", ack0, ack1, mem_we_); end
    idle_inputs();
    tick();
    reset_ = 1;
  endtask

  task automatic test_idle();
    idle_inputs();
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0 || mem_we_ !== 1'b1 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
        errors++; $display("FAIL idle[%0d] got ack=%b%b we_=%b rvalid=%b%b want 00 1 00", k, ack0, ack1, mem_we_, rvalid0, rvalid1); end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    reset_ = 0;
    #1;
    test_reset();
    test_write_read();
    test_round_robin();
    test_ordering();
    test_lock();
    test_reset_after_read();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
